// File: rtl/seg7_result_scan_if.sv
// Display-side bundle between the memory/IO result port and the
// seven-segment pins. The display block is the slave: it consumes
// result/freeze and drives the digit/segment pins.
interface seg7_result_scan_if;
  logic [15:0] result;
  logic        freeze;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  // Producer / board side: supplies the value, observes the pins
  modport master (
    output result,
    output freeze,
    input  an,
    input  seg,
    input  dp
  );

  // Display block side
  modport slave (
    input  result,
    input  freeze,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/seg7_result_scan.sv
// Four-digit multiplexed hex display of the 16-bit result port with
// leading-zero blanking and a digit-0 decimal-point flash whenever the
// captured value changes. All pins are registered.
module seg7_result_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int FLASH_CYCLES   = 5000000,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_result_scan_if.slave  bus
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FLASH_W = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

  // Inactive pin levels depend on the board polarity
  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0)  ? 4'b1111 : 4'b0000;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [15:0]        r_shown_val;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [1:0]         r_digit_idx;
  logic [FLASH_W-1:0] r_flash_cnt;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic       w_change;
  logic [3:0] w_blank;
  logic [3:0] w_an_onehot;
  logic [3:0] w_nibble;
  logic [6:0] w_seg_on;
  logic       w_dp_on;

  // A change is only seen when the new value will actually be captured
  assign w_change = !bus.freeze && (bus.result != r_shown_val);

  // Capture the producer's value unless frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shown_val <= 16'h0000;
    end else if (!bus.freeze) begin
      r_shown_val <= bus.result;
    end
  end

  // Dwell counter and digit selector, rotating 0,1,2,3,0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt   <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_div_cnt   <= r_div_cnt + 1'b1;
    end
  end

  // Flash timer: reload on every change, otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flash_cnt <= '0;
    end else if (w_change) begin
      r_flash_cnt <= FLASH_LOAD;
    end else if (r_flash_cnt != '0) begin
      r_flash_cnt <= r_flash_cnt - 1'b1;
    end
  end

  // Digit k is blank when it and every digit to its left are zero;
  // the rightmost digit always shows so a zero value reads "0".
  assign w_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign w_blank[gi] = (LZ_BLANK != 0) && (r_shown_val[15:4*gi] == '0);
    end
  endgenerate

  // One-hot enable for the selected digit, suppressed when blanked
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign w_an_onehot[gi] = (r_digit_idx == 2'(gi)) && !w_blank[gi];
    end
  endgenerate

  assign w_nibble = r_shown_val[{r_digit_idx, 2'b00} +: 4];
  assign w_dp_on  = (r_digit_idx == 2'd0) && (r_flash_cnt != '0);

  // Hex to active-high segment pattern {g,f,e,d,c,b,a}
  always_comb begin
    w_seg_on = 7'h00;
    case (w_nibble)
      4'h0: w_seg_on = 7'h3F;
      4'h1: w_seg_on = 7'h06;
      4'h2: w_seg_on = 7'h5B;
      4'h3: w_seg_on = 7'h4F;
      4'h4: w_seg_on = 7'h66;
      4'h5: w_seg_on = 7'h6D;
      4'h6: w_seg_on = 7'h7D;
      4'h7: w_seg_on = 7'h07;
      4'h8: w_seg_on = 7'h7F;
      4'h9: w_seg_on = 7'h6F;
      4'hA: w_seg_on = 7'h77;
      4'hB: w_seg_on = 7'h7C;
      4'hC: w_seg_on = 7'h39;
      4'hD: w_seg_on = 7'h5E;
      4'hE: w_seg_on = 7'h79;
      4'hF: w_seg_on = 7'h71;
      default: w_seg_on = 7'h00;
    endcase
  end

  // Register the pins from this cycle's digit, value and flash state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_an <= (AN_ACTIVE_LOW != 0) ? ~w_an_onehot : w_an_onehot;
      if (w_blank[r_digit_idx]) begin
        r_seg <= SEG_OFF;
        r_dp  <= DP_OFF;
      end else begin
        r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
        r_dp  <= (SEG_ACTIVE_LOW != 0) ? ~w_dp_on : w_dp_on;
      end
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_result_scan.sv
// Bench for seg7_result_scan with a fast scan (4 cycles per digit) and a
// short flash (10 cycles). A reference model predicts the pins from the
// cycle count since reset, the displayed value and the flash time left.
module tb_seg7_result_scan;

  localparam int SCAN_DIV     = 4;
  localparam int FLASH_CYCLES = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seg7_result_scan_if u_if ();

  seg7_result_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .FLASH_CYCLES   (FLASH_CYCLES),
    .LZ_BLANK       (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high segment patterns indexed by hex digit
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
    seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
    seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
    seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
  end

  // Reference model state
  logic [15:0] m_val;
  int          m_flash;
  int          m_cycle;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val   = 16'h0000;
    m_flash = 0;
    m_cycle = 0;
  endtask

  // Advance n clocks; predict each edge's pins and compare on the falling edge
  task automatic run(input int n);
    int  k;
    int  nib;
    bit  blank;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k     = (m_cycle / SCAN_DIV) % 4;
      nib   = (m_val >> (4 * k)) & 15;
      blank = (k != 0) && ((m_val >> (4 * k)) == 0);
      e_an  = blank ? 4'b1111 : ~(4'b0001 << k);
      e_seg = blank ? 7'b1111111 : ~seg_tab[nib];
      e_dp  = !((k == 0) && (m_flash > 0));
      if (!u_if.freeze && (u_if.result != m_val)) m_flash = FLASH_CYCLES;
      else if (m_flash > 0) m_flash--;
      if (!u_if.freeze) m_val = u_if.result;
      m_cycle++;
      @(negedge clk);
      chk("an",  {3'b000, u_if.an}, {3'b000, e_an});
      chk("seg", u_if.seg, e_seg);
      chk("dp",  {6'b0, u_if.dp}, {6'b0, e_dp});
    end
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, "_an"},  {3'b000, u_if.an}, 7'b0001111);
    chk({tag, "_seg"}, u_if.seg, 7'b1111111);
    chk({tag, "_dp"},  {6'b0, u_if.dp}, 7'b0000001);
  endtask

  initial begin
    logic [15:0] mask;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    u_if.result = 16'h0000;
    u_if.freeze = 1'b0;
    model_reset();

    // Held in reset: everything inactive
    repeat (3) @(negedge clk);
    chk_inactive("reset");

    // Release with a zero value: first edge shows "0" on digit 0
    rst_n = 1'b1;
    run(1);
    chk("first_an",  {3'b000, u_if.an}, 7'b0001110);
    chk("first_seg", u_if.seg, 7'b1000000);
    run(20);

    // Full four-digit value
    u_if.result = 16'h1A2F;
    run(20);
    chk("1A2F_dp_flash_over", {6'b0, u_if.dp}, 7'b0000001);

    // Leading zeros blanked
    u_if.result = 16'h0030;
    run(20);

    // Freeze holds the captured value and suppresses the flash
    u_if.result = 16'h1234;
    run(15);
    u_if.freeze = 1'b1;
    u_if.result = 16'hBEEF;
    run(20);
    u_if.freeze = 1'b0;
    run(20);

    // Flash, then a second change part-way through extends it
    u_if.result = 16'h0005;
    run(16);
    u_if.result = 16'h0006;
    run(5);
    u_if.result = 16'h0007;
    run(20);

    // Randomised values, widths and freeze
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 16'h000F;
          1: mask = 16'h00FF;
          2: mask = 16'h0FFF;
          default: mask = 16'hFFFF;
        endcase
        u_if.result = 16'($urandom) & mask;
      end
      u_if.freeze = ($urandom_range(0, 4) == 0);
      run(1);
    end
    u_if.freeze = 1'b0;

    // Reset in a digit-2 slot while a flash is running
    u_if.result = 16'h0123;
    run(2);
    while (((m_cycle / SCAN_DIV) % 4) != 2) run(1);
    u_if.result = 16'h0456;
    run(1);
    #2 rst_n = 1'b0;
    #1 chk_inactive("midreset");
    model_reset();
    u_if.result = 16'h0000;
    repeat (2) @(negedge clk);
    chk_inactive("midreset_hold");
    rst_n = 1'b1;
    run(1);
    chk("restart_an", {3'b000, u_if.an}, 7'b0001110);
    chk("restart_dp", {6'b0, u_if.dp}, 7'b0000001);
    run(24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
